// File: rtl/fetch_pkg.sv
// Shared types and defaults for the dual-issue fetch sequencer.
// The optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
package fetch_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int INSTR_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    // One fetch-queue entry: an instruction pair plus the PC it came from.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr1;
        logic [INSTR_WIDTH-1:0] instr2;
        logic [PC_WIDTH-1:0]    pc;
        logic                   pred_taken;
    } fq_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched instruction pairs for decode.
// Flush empties the queue in one cycle; flush wins over push and pop.
module fetch_queue #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the fetch PC, selects the next PC from
// redirect / BTB prediction / PC+2, and buffers fetched pairs for decode.
// Define FETCH_PERF_CNT_EN to add saturating event counters.
module fetch_sequencer #(
    parameter int PC_WIDTH    = fetch_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter int FQ_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hlt_i,
    input  logic                        redirect_valid_i,
    input  logic [PC_WIDTH-1:0]         redirect_pc_i,
    input  logic                        pred_hit_i,
    input  logic                        pred_taken_i,
    input  logic [PC_WIDTH-1:0]         pred_target_i,
    input  logic [INSTR_WIDTH-1:0]      instr1_i,
    input  logic [INSTR_WIDTH-1:0]      instr2_i,
    output logic [PC_WIDTH-1:0]         fetch_pc_o,
    output logic                        fetch_en_o,
    output logic                        deq_valid_o,
    input  logic                        deq_ready_i,
    output logic [INSTR_WIDTH-1:0]      deq_instr1_o,
    output logic [INSTR_WIDTH-1:0]      deq_instr2_o,
    output logic [PC_WIDTH-1:0]         deq_pc_o,
    output logic                        deq_pred_taken_o,
    output logic [$clog2(FQ_DEPTH):0]   fq_count_o,
    output logic                        halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_fetch_o,
    output logic [31:0]                 perf_stall_o,
    output logic [31:0]                 perf_redirect_o,
    output logic [31:0]                 perf_pred_o
`endif
);

    import fetch_pkg::*;

    localparam int EW = 2 * INSTR_WIDTH + PC_WIDTH + 1;

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  pred_taken;
    logic                  q_full;
    logic                  q_pop;
    logic [EW-1:0]         q_wdata;
    logic [EW-1:0]         q_rdata;

    assign pred_taken  = pred_hit_i & pred_taken_i;
    assign fetch_en_o  = (state_q == RUN) && !q_full && !redirect_valid_i && !hlt_i;
    assign deq_valid_o = (fq_count_o != '0) && !redirect_valid_i;
    assign q_pop       = deq_valid_o && deq_ready_i;
    assign q_wdata     = {instr1_i, instr2_i, pc_q, pred_taken};
    assign fetch_pc_o  = pc_q;
    assign halted_o    = (state_q == HALTED);
    assign {deq_instr1_o, deq_instr2_o, deq_pc_o, deq_pred_taken_o} = q_rdata;

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid_i),
        .push  (fetch_en_o),
        .pop   (q_pop),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .count (fq_count_o),
        .full  (q_full)
    );

    // State and fetch PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next-PC selection; a redirect overrides everything but never changes state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (hlt_i) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (fetch_en_o) begin
            pc_d = pred_taken ? pred_target_i : pc_q + PC_WIDTH'(2);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; only reset clears them, flushes do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_o    <= '0;
            perf_stall_o    <= '0;
            perf_redirect_o <= '0;
            perf_pred_o     <= '0;
        end else begin
            if (fetch_en_o)                 perf_fetch_o    <= sat_inc(perf_fetch_o);
            if (state_q == RUN && q_full)   perf_stall_o    <= sat_inc(perf_stall_o);
            if (redirect_valid_i)           perf_redirect_o <= sat_inc(perf_redirect_o);
            if (fetch_en_o && pred_taken)   perf_pred_o     <= sat_inc(perf_pred_o);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// traffic against a queue-based reference model with a decoupled head monitor.
module tb_fetch_sequencer;

    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hlt_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic        pred_hit_i = 1'b0;
    logic        pred_taken_i = 1'b0;
    logic [15:0] pred_target_i = '0;
    logic [31:0] instr1_i = '0;
    logic [31:0] instr2_i = '0;
    logic        deq_ready_i = 1'b0;
    logic [15:0] fetch_pc_o;
    logic        fetch_en_o;
    logic        deq_valid_o;
    logic [31:0] deq_instr1_o;
    logic [31:0] deq_instr2_o;
    logic [15:0] deq_pc_o;
    logic        deq_pred_taken_o;
    logic [2:0]  fq_count_o;
    logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_redirect_o;
    logic [31:0] perf_pred_o;
    int unsigned m_perf_fetch;
    int unsigned m_perf_stall;
    int unsigned m_perf_redirect;
    int unsigned m_perf_pred;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: expected queue contents, fetch PC and lifecycle flags.
    fq_entry_t   exp_q[$];
    logic [15:0] m_pc;
    logic        m_booting;
    logic        m_halted;

    fetch_sequencer #(
        .PC_WIDTH    (16),
        .INSTR_WIDTH (32),
        .FQ_DEPTH    (DEPTH),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hlt_i            (hlt_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pred_hit_i       (pred_hit_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .instr1_i         (instr1_i),
        .instr2_i         (instr2_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_en_o       (fetch_en_o),
        .deq_valid_o      (deq_valid_o),
        .deq_ready_i      (deq_ready_i),
        .deq_instr1_o     (deq_instr1_o),
        .deq_instr2_o     (deq_instr2_o),
        .deq_pc_o         (deq_pc_o),
        .deq_pred_taken_o (deq_pred_taken_o),
        .fq_count_o       (fq_count_o),
        .halted_o         (halted_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_o     (perf_fetch_o),
        .perf_stall_o     (perf_stall_o),
        .perf_redirect_o  (perf_redirect_o),
        .perf_pred_o      (perf_pred_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the coming edge.
    task automatic checkOutput();
        logic      exp_fen;
        logic      exp_dv;
        logic      running;
        fq_entry_t e;
        running = !m_booting && !m_halted;
        exp_fen = running && (exp_q.size() < DEPTH) && !redirect_valid_i && !hlt_i;
        exp_dv  = (exp_q.size() != 0) && !redirect_valid_i;
        check("fetch_pc", 64'(fetch_pc_o), 64'(m_pc));
        check("fetch_en", 64'(fetch_en_o), 64'(exp_fen));
        check("deq_valid", 64'(deq_valid_o), 64'(exp_dv));
        check("fq_count", 64'(fq_count_o), 64'(exp_q.size()));
        check("halted", 64'(halted_o), 64'(m_halted));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", 64'(perf_fetch_o), 64'(m_perf_fetch));
        check("perf_stall", 64'(perf_stall_o), 64'(m_perf_stall));
        check("perf_redirect", 64'(perf_redirect_o), 64'(m_perf_redirect));
        check("perf_pred", 64'(perf_pred_o), 64'(m_perf_pred));
        if (exp_fen) m_perf_fetch++;
        if (running && exp_q.size() == DEPTH) m_perf_stall++;
        if (redirect_valid_i) m_perf_redirect++;
        if (exp_fen && pred_hit_i && pred_taken_i) m_perf_pred++;
`endif
        if (redirect_valid_i) begin
            exp_q.delete();
        end else if (exp_fen) begin
            e.instr1     = instr1_i;
            e.instr2     = instr2_i;
            e.pc         = m_pc;
            e.pred_taken = pred_hit_i && pred_taken_i;
            exp_q.push_back(e);
        end
        if (redirect_valid_i)              m_pc = redirect_pc_i;
        else if (exp_fen && e.pred_taken)  m_pc = pred_target_i;
        else if (exp_fen)                  m_pc = m_pc + 16'd2;
        if (m_booting)                     m_booting = 1'b0;
        else if (!m_halted && hlt_i)       m_halted = 1'b1;
    endtask

    task automatic applyStimulus(input logic hlt, input logic redir, input logic [15:0] rpc,
                                 input logic hit, input logic taken, input logic [15:0] tgt,
                                 input logic rdy);
        @(negedge clk);
        hlt_i            = hlt;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        pred_hit_i       = hit;
        pred_taken_i     = taken;
        pred_target_i    = tgt;
        deq_ready_i      = rdy;
        instr1_i         = $urandom;
        instr2_i         = $urandom;
        #1;
        checkOutput();
    endtask

    // Asynchronous reset mid-cycle, checked immediately, released away from the clock edge.
    task automatic doReset();
        @(negedge clk);
        rst_n            = 1'b0;
        hlt_i            = 1'b0;
        redirect_valid_i = 1'b0;
        pred_hit_i       = 1'b0;
        pred_taken_i     = 1'b0;
        deq_ready_i      = 1'b0;
        exp_q.delete();
        m_pc      = 16'h0000;
        m_booting = 1'b1;
        m_halted  = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        m_perf_fetch    = 0;
        m_perf_stall    = 0;
        m_perf_redirect = 0;
        m_perf_pred     = 0;
`endif
        #1;
        check("rst_fetch_pc", 64'(fetch_pc_o), 64'h0);
        check("rst_fetch_en", 64'(fetch_en_o), 64'h0);
        check("rst_deq_valid", 64'(deq_valid_o), 64'h0);
        check("rst_fq_count", 64'(fq_count_o), 64'h0);
        check("rst_halted", 64'(halted_o), 64'h0);
        check("rst_head", 64'({deq_pc_o, deq_instr1_o, deq_pred_taken_o}), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: whenever the head is presented, compare it with the oldest expected entry.
    initial begin
        fq_entry_t f;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && deq_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("head_unexpected", 64'(deq_valid_o), 64'h0);
                end else begin
                    f = exp_q[0];
                    check("head_pc", 64'(deq_pc_o), 64'(f.pc));
                    check("head_instr1", 64'(deq_instr1_o), 64'(f.instr1));
                    check("head_instr2", 64'(deq_instr2_o), 64'(f.instr2));
                    check("head_pred", 64'(deq_pred_taken_o), 64'(f.pred_taken));
                    if (deq_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        $display("[TB] fetch_sequencer bench start");

        // Sequential fetch with decode always ready.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Fill the queue with decode stalled, then release it.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        check("full_pc_held", 64'(fetch_pc_o), 64'h8);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Predicted-taken branch at PC 4 to 0x40.
        doReset();
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 0, m_pc == 16'h4, m_pc == 16'h4, 16'h0040, 1);

        // Redirect with three entries queued.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 16'h0100, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Halt with two entries queued, drain, then reset out of HALTED.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 16'h0200, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // PC wrap from 0xFFFE to 0x0000.
        doReset();
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 16'hFFFE, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Randomised traffic with periodic resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) doReset();
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 15) == 0,
                          16'($urandom),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1,
                          16'($urandom),
                          $urandom_range(0, 9) < 7);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the fetch PC register and sequences the dual-issue fetch stage: picks the next PC from branch redirect, BTB prediction or sequential PC+2, and raises fetch enable to instruction memory. Buffers fetched instruction pairs in a small FIFO fetch queue feeding decode. Handles stall (queue full), flush on redirect, and halt.

Parameters:
PC_WIDTH, 16, fetch PC width
INSTR_WIDTH, 32, width of each instruction slot
FQ_DEPTH, 4, fetch-queue entries, one instruction pair each; power of 2, at least 2
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hlt_i  in  1  halt request; sticky until reset
redirect_valid_i  in  1  branch resolved mispredict/taken (PCSrc)
redirect_pc_i  in  PC_WIDTH  resolved branch target
pred_hit_i  in  1  BTB hit for fetch_pc_o, same cycle
pred_taken_i  in  1  BTB prediction for fetch_pc_o
pred_target_i  in  PC_WIDTH  BTB predicted target
instr1_i  in  INSTR_WIDTH  IM slot 0 for fetch_pc_o, combinational same cycle
instr2_i  in  INSTR_WIDTH  IM slot 1
fetch_pc_o  out  PC_WIDTH  current fetch PC (registered)
fetch_en_o  out  1  IM read enable
deq_valid_o  out  1  queue head valid
deq_ready_i  in  1  decode accepts head
deq_instr1_o  out  INSTR_WIDTH  head slot 0
deq_instr2_o  out  INSTR_WIDTH  head slot 1
deq_pc_o  out  PC_WIDTH  head PC
deq_pred_taken_o  out  1  head was fetched on a predicted-taken path
fq_count_o  out  $clog2(FQ_DEPTH)+1  occupancy
halted_o  out  1  in HALTED state

Behaviour:
- Reset (async, rst_n=0): state=BOOT, fetch_pc_o=RESET_PC, queue pointers and count=0, all queue outputs 0, fetch_en_o=0, halted_o=0.
- FSM: BOOT -> RUN after exactly one cycle. RUN -> HALTED when hlt_i=1 at an edge. HALTED is left only by reset.
- fetch_en_o = (state==RUN) && (fq_count_o < FQ_DEPTH) && !redirect_valid_i && !hlt_i. It never depends on deq_ready_i.
- Enqueue on fetch_en_o: push {instr1_i, instr2_i, fetch_pc_o, pred_hit_i&pred_taken_i}.
- Next-PC priority at each edge:
  1. redirect_valid_i: PC<=redirect_pc_i. Queue flushed, so count=0 next cycle. No enqueue and no dequeue this cycle.
  2. Otherwise, if fetch_en_o: PC<=pred_target_i when pred_hit_i&&pred_taken_i, else PC+2. Addition is modulo 2^PC_WIDTH and wraps 16'hFFFE -> 16'h0000.
  3. Otherwise PC holds.
- Redirect is honoured in any state, including BOOT and HALTED: PC updates and queue flushes, but the state is unchanged. A redirect and hlt_i in the same cycle: PC loads the target and the state goes to HALTED.
- deq_valid_o = (fq_count_o!=0) && !redirect_valid_i. A dequeue fires on deq_valid_o && deq_ready_i and pops the head.
- Simultaneous enqueue and dequeue leaves the count unchanged. This is allowed when full only if the dequeue fires, but fetch_en_o is 0 when full, so a full queue never enqueues.
- Head outputs are driven from the queue array at the read pointer. Read and write pointers wrap modulo FQ_DEPTH.
- In HALTED: no fetches. The queue still drains to decode.
- Latency: an instruction fetched in cycle N is visible at the head in N+1 if the queue was empty. Redirect to first fetch at the new PC is 1 cycle.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds 32-bit output counters perf_fetch_o (fetch_en_o cycles), perf_stall_o (RUN cycles with a full queue), perf_redirect_o (redirects) and perf_pred_o (predicted-taken fetches). All reset to 0, saturate at 32'hFFFFFFFF, and are not cleared by flush.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: PC_WIDTH, INSTR_WIDTH, RESET_PC, the FSM state enum {BOOT, RUN, HALTED}, and the fq_entry_t struct {instr1, instr2, pc, pred_taken}.
- One sub-module, fetch_queue: parameterised sync FIFO with flush, count and registered pointers.
- fetch_sequencer keeps the FSM and next-PC mux.

Test Plan:
- Reset, hlt_i=0, deq_ready_i=1, no prediction -> cycle 1 fetch_en_o=0 (BOOT); fetch_pc_o sequence 0,0,2,4,6; deq_pc_o 0,2,4 one cycle later each.
- deq_ready_i=0, FQ_DEPTH=4 -> after 4 fetches fq_count_o=4 and fetch_en_o=0 with PC held at 16'h0008. Raise deq_ready_i -> fetch resumes the next cycle.
- pred_hit_i=1, pred_taken_i=1, pred_target_i=16'h0040 at PC 16'h0004 -> next fetch_pc_o=16'h0040; entry for PC 4 has deq_pred_taken_o=1.
- Queue holding 3 entries, redirect_valid_i with redirect_pc_i=16'h0100 -> deq_valid_o=0 that cycle; next cycle fq_count_o=0 and fetch_pc_o=16'h0100; the following cycle deq_pc_o=16'h0100.
- hlt_i pulse with 2 entries queued -> halted_o=1 and fetch_en_o=0 from then on; queue drains 2 entries; stays halted after hlt_i drops; a mid-HALTED rst_n=0 returns to BOOT with PC=RESET_PC.
- PC at 16'hFFFE, sequential fetch -> next fetch_pc_o=16'h0000. With FETCH_PERF_CNT_EN defined, perf counters match the counted events above.
